dmem_responder: RTL and testbench



---
 rtl/dmem_map_pkg.sv | 44 ++++
 rtl/dmem_responder_fifo.sv | 76 +++++++
 rtl/dmem_responder.sv | 133 +++++++++++++
 tb/tb_dmem_responder.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_map_pkg.sv
// ---------------------------------------------------------------------------
// dmem_map_pkg
// Address map shared by the dmem responder and its helpers.
//   - Word addresses of the MMIO registers at the top of the 4K word space.
//   - Bit positions of the STATUS register fields.
//   - Decoded-region enum plus the decode function used by the top level.
// ---------------------------------------------------------------------------
package dmem_map_pkg;

   localparam logic [11:0] ADDR_CYCLE   = 12'hFF0;
   localparam logic [11:0] ADDR_DBG     = 12'hFF1;
   localparam logic [11:0] ADDR_STATUS  = 12'hFF2;
   localparam logic [11:0] ADDR_SCRATCH = 12'hFF3;

   // STATUS = {23'b0, overflow, full, empty, 1'b0, count[4:0]}
   localparam int STATUS_OVF_BIT   = 8;
   localparam int STATUS_FULL_BIT  = 7;
   localparam int STATUS_EMPTY_BIT = 6;
   localparam int STATUS_COUNT_W   = 5;

   typedef enum logic [2:0] {
      REG_RAM,
      REG_CYCLE,
      REG_DBG,
      REG_STATUS,
      REG_SCRATCH,
      REG_UNMAPPED
   } region_e;

   // RAM occupies 0..ram_limit-1; RAM takes priority should it ever reach
   // the MMIO page.
   function automatic region_e decode_region(input logic [11:0] addr,
                                             input logic [12:0] ram_limit);
      if ({1'b0, addr} < ram_limit) return REG_RAM;
      case (addr)
         ADDR_CYCLE:   return REG_CYCLE;
         ADDR_DBG:     return REG_DBG;
         ADDR_STATUS:  return REG_STATUS;
         ADDR_SCRATCH: return REG_SCRATCH;
         default:      return REG_UNMAPPED;
      endcase
   endfunction

endpackage

// File: rtl/dmem_responder_fifo.sv
// ---------------------------------------------------------------------------
// dbg_fifo
// Debug-output FIFO with a registered head word.
//   clock, reset : clock and asynchronous active-high reset
//   push         : write push_data (caller guarantees room, or a same-cycle pop)
//   push_data    : word to enqueue
//   pop          : drop the head entry (caller guarantees not empty)
//   head         : registered head entry; holds its last value while empty
//   count        : occupancy 0..FIFO_DEPTH
//   full, empty  : occupancy flags derived from count
// ---------------------------------------------------------------------------
module dbg_fifo #(
   parameter int FIFO_DEPTH = 4,
   parameter int WIDTH      = 32,
   parameter int CW         = $clog2(FIFO_DEPTH) + 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [PW-1:0] LAST = PW'(FIFO_DEPTH - 1);

   logic [WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;

   function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
      return (p == LAST) ? '0 : p + PW'(1);
   endfunction

   assign full  = (count == CW'(FIFO_DEPTH));
   assign empty = (count == '0);

   // NOTE: storage arrays carry no reset; the pointers and count define which
   // entries are meaningful, so a reset only has to clear those.
   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   // NOTE: sequential state is always assigned with <= so every register
   // samples the pre-edge values of its neighbours.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         head   <= '0;
      end else begin
         if (push) wr_ptr <= inc_ptr(wr_ptr);
         if (pop)  rd_ptr <= inc_ptr(rd_ptr);

         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase

         // The head register tracks what will be at rd_ptr after this edge.
         // A pushed word becomes the head when it lands in an empty FIFO or
         // replaces the only entry being popped; it is not in mem yet.
         if (push && (empty || (pop && count == CW'(1))))
            head <= push_data;
         else if (pop && count > CW'(1))
            head <= mem[inc_ptr(rd_ptr)];
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
// Services processor dmem load/store requests: backing word RAM in the low
// address range plus an MMIO page (cycle counter, debug FIFO, status,
// scratch) at 0xFF0..0xFF3.
//   clock, reset  : single clock, asynchronous active-high reset
//   address_dmem  : word address of the request
//   data, wren    : store data and store strobe
//   rden          : load strobe; q_dmem/q_valid answer one cycle later
//   q_dmem        : load data (holds while q_valid is low)
//   q_valid       : load data valid
//   err_unmapped  : one-cycle pulse after any access to an unmapped address
//   dbg_valid     : debug FIFO not empty
//   dbg_data      : debug FIFO head word
//   dbg_ready     : consumer takes the head when high with dbg_valid
// ---------------------------------------------------------------------------
module dmem_responder
   import dmem_map_pkg::*;
#(
   parameter int RAM_WORDS  = 1024,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [11:0] address_dmem,
   input  logic [31:0] data,
   input  logic        wren,
   input  logic        rden,
   output logic [31:0] q_dmem,
   output logic        q_valid,
   output logic        err_unmapped,
   output logic        dbg_valid,
   output logic [31:0] dbg_data,
   input  logic        dbg_ready
);

   localparam int RAM_AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
   localparam int CW     = $clog2(FIFO_DEPTH) + 1;
   localparam logic [12:0] RAM_LIMIT = 13'(RAM_WORDS);

   region_e            region;
   logic [RAM_AW-1:0]  ram_idx;
   logic [31:0]        ram [RAM_WORDS];
   logic [31:0]        cycle_cnt;
   logic [31:0]        scratch;
   logic               overflow;
   logic [31:0]        status_word;
   logic [31:0]        rd_word;

   logic               dbg_push_req;
   logic               fifo_push;
   logic               fifo_pop;
   logic [CW-1:0]      fifo_count;
   logic               fifo_full;
   logic               fifo_empty;

   assign region  = decode_region(address_dmem, RAM_LIMIT);
   assign ram_idx = address_dmem[RAM_AW-1:0];

   // A push into a full FIFO still succeeds when the head leaves this cycle.
   assign fifo_pop     = dbg_valid & dbg_ready;
   assign dbg_push_req = wren & (region == REG_DBG);
   assign fifo_push    = dbg_push_req & (~fifo_full | fifo_pop);
   assign dbg_valid    = ~fifo_empty;

   dbg_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .WIDTH      (32),
      .CW         (CW)
   ) u_dbg_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (fifo_push),
      .push_data (data),
      .pop       (fifo_pop),
      .head      (dbg_data),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_ff @(posedge clock) begin
      if (wren && region == REG_RAM) ram[ram_idx] <= data;
   end

   // NOTE: every always_comb output gets a default before any branch, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      status_word                    = '0;
      status_word[STATUS_OVF_BIT]    = overflow;
      status_word[STATUS_FULL_BIT]   = fifo_full;
      status_word[STATUS_EMPTY_BIT]  = fifo_empty;
      status_word[STATUS_COUNT_W-1:0] = STATUS_COUNT_W'(fifo_count);
   end

   // Read mux sees pre-edge state, which gives read-first behaviour for a
   // same-cycle store and the counter value held during the request cycle.
   always_comb begin
      rd_word = '0;
      case (region)
         REG_RAM:     rd_word = ram[ram_idx];
         REG_CYCLE:   rd_word = cycle_cnt;
         REG_STATUS:  rd_word = status_word;
         REG_SCRATCH: rd_word = scratch;
         default:     rd_word = '0;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         q_dmem       <= '0;
         q_valid      <= 1'b0;
         err_unmapped <= 1'b0;
         cycle_cnt    <= '0;
         scratch      <= '0;
         overflow     <= 1'b0;
      end else begin
         q_valid      <= rden;
         if (rden) q_dmem <= rd_word;
         err_unmapped <= (rden | wren) & (region == REG_UNMAPPED);

         if (wren && region == REG_CYCLE) cycle_cnt <= '0;
         else                             cycle_cnt <= cycle_cnt + 32'd1;

         if (wren && region == REG_SCRATCH) scratch <= data;

         // A dropped push sets overflow even if STATUS is cleared this cycle.
         if (dbg_push_req && !fifo_push)              overflow <= 1'b1;
         else if (wren && region == REG_STATUS)       overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
// Drives dmem requests and keeps a behavioural model (associative RAM, queue
// FIFO, counter as cycles-since-clear). Each driven cycle pushes the expected
// response into a scoreboard; a monitor pops one entry per clock and compares.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

   localparam int RAM_WORDS = 1024;
   localparam int DEPTH     = 4;

   logic        clock = 1'b0;
   logic        reset;
   logic [11:0] address_dmem;
   logic [31:0] data;
   logic        wren;
   logic        rden;
   logic [31:0] q_dmem;
   logic        q_valid;
   logic        err_unmapped;
   logic        dbg_valid;
   logic [31:0] dbg_data;
   logic        dbg_ready;

   dmem_responder #(.RAM_WORDS(RAM_WORDS), .FIFO_DEPTH(DEPTH)) dut (
      .clock        (clock),
      .reset        (reset),
      .address_dmem (address_dmem),
      .data         (data),
      .wren         (wren),
      .rden         (rden),
      .q_dmem       (q_dmem),
      .q_valid      (q_valid),
      .err_unmapped (err_unmapped),
      .dbg_valid    (dbg_valid),
      .dbg_data     (dbg_data),
      .dbg_ready    (dbg_ready)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        valid;
      logic        chk;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t        sb[$];
   int          checks   = 0;
   int          failures = 0;

   // reference model state
   logic [31:0] ram_m [int];
   logic [31:0] fq[$];
   logic [31:0] scratch_m;
   logic [31:0] cnt_base;
   logic [31:0] disp;
   logic        ovf;
   int          cyc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_status();
      logic [31:0] s;
      s = '0;
      s[8]   = ovf;
      s[7]   = (fq.size() == DEPTH);
      s[6]   = (fq.size() == 0);
      s[4:0] = 5'(fq.size());
      return s;
   endfunction

   task automatic model_reset();
      ram_m.delete();
      fq.delete();
      sb.delete();
      scratch_m = '0;
      cnt_base  = '0;
      disp      = '0;
      ovf       = 1'b0;
      cyc       = 0;
   endtask

   // One request cycle: check debug outputs, drive, record expectation,
   // advance the model past the coming edge.
   task automatic cycle(input logic w, input logic r, input logic [11:0] a,
                        input logic [31:0] d, input logic rdy);
      exp_t e;
      int   ai;
      bit   ovf_set;
      @(negedge clock);
      check("dbg_valid", 32'(dbg_valid), 32'(fq.size() != 0));
      check("dbg_data", dbg_data, disp);
      wren = w; rden = r; address_dmem = a; data = d; dbg_ready = rdy;
      ai = int'(a);
      e.valid = r; e.chk = r; e.rdata = '0; e.err = 1'b0;
      if (ai < RAM_WORDS) begin
         if (ram_m.exists(ai)) e.rdata = ram_m[ai];
         else                  e.chk = 1'b0;
      end
      else if (a == 12'hFF0) e.rdata = 32'(cyc) - cnt_base;
      else if (a == 12'hFF1) e.rdata = '0;
      else if (a == 12'hFF2) e.rdata = model_status();
      else if (a == 12'hFF3) e.rdata = scratch_m;
      else e.err = r | w;
      sb.push_back(e);

      if (rdy && fq.size() != 0) void'(fq.pop_front());
      ovf_set = 1'b0;
      if (w) begin
         if (ai < RAM_WORDS)     ram_m[ai] = d;
         else if (a == 12'hFF0)  cnt_base = 32'(cyc + 1);
         else if (a == 12'hFF1) begin
            if (fq.size() < DEPTH) fq.push_back(d);
            else                   ovf_set = 1'b1;
         end
         else if (a == 12'hFF3)  scratch_m = d;
      end
      if (ovf_set)                   ovf = 1'b1;
      else if (w && a == 12'hFF2)    ovf = 1'b0;
      if (fq.size() != 0) disp = fq[0];
      cyc++;
   endtask

   task automatic idle(input int n, input logic rdy);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 12'h000, 32'h0, rdy);
   endtask

   // Monitor: one scoreboard entry per clock edge after it was issued.
   initial begin
      exp_t m;
      forever begin
         @(posedge clock);
         #1;
         if (sb.size() != 0) begin
            m = sb.pop_front();
            check("q_valid", 32'(q_valid), 32'(m.valid));
            if (m.chk) check("q_dmem", q_dmem, m.rdata);
            check("err_unmapped", 32'(err_unmapped), 32'(m.err));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic [11:0] a;
      logic        w, r, rdy;
      int          sel;

      reset = 1'b1; wren = 1'b0; rden = 1'b0; address_dmem = '0;
      data = '0; dbg_ready = 1'b0;
      model_reset();
      @(posedge clock); @(posedge clock); #2;
      check("rst_q_dmem", q_dmem, 32'h0);
      check("rst_q_valid", 32'(q_valid), 32'h0);
      check("rst_err", 32'(err_unmapped), 32'h0);
      check("rst_dbg_valid", 32'(dbg_valid), 32'h0);
      check("rst_dbg_data", dbg_data, 32'h0);
      reset = 1'b0;

      // status and counter straight out of reset
      cycle(1'b0, 1'b1, 12'hFF2, 32'h0, 1'b0);
      cycle(1'b0, 1'b1, 12'hFF0, 32'h0, 1'b0);

      // store then load, then an idle cycle must show q_valid low
      cycle(1'b1, 1'b0, 12'h005, 32'h1234_5678, 1'b0);
      cycle(1'b0, 1'b1, 12'h005, 32'h0, 1'b0);
      idle(1, 1'b0);

      // read-first on same-cycle store and load
      cycle(1'b1, 1'b0, 12'h010, 32'h0000_000A, 1'b0);
      cycle(1'b1, 1'b1, 12'h010, 32'h0000_000B, 1'b0);
      cycle(1'b0, 1'b1, 12'h010, 32'h0, 1'b0);

      // RAM upper boundary and first unmapped word above it
      cycle(1'b1, 1'b0, 12'h3FF, 32'hCAFE_F00D, 1'b0);
      cycle(1'b0, 1'b1, 12'h3FF, 32'h0, 1'b0);
      cycle(1'b0, 1'b1, 12'h400, 32'h0, 1'b0);

      // scratch
      cycle(1'b1, 1'b0, 12'hFF3, 32'hA5A5_5A5A, 1'b0);
      cycle(1'b0, 1'b1, 12'hFF3, 32'h0, 1'b0);

      // counter clear, run, read; then wrap from all-ones
      cycle(1'b1, 1'b0, 12'hFF0, 32'hDEAD_BEEF, 1'b0);
      idle(9, 1'b0);
      cycle(1'b0, 1'b1, 12'hFF0, 32'h0, 1'b0);
      @(posedge clock); #2;
      force dut.cycle_cnt = 32'hFFFF_FFFF;
      #1;
      release dut.cycle_cnt;
      cnt_base = 32'(cyc) + 32'd1;
      cycle(1'b0, 1'b1, 12'hFF0, 32'h0, 1'b0);
      cycle(1'b0, 1'b1, 12'hFF0, 32'h0, 1'b0);

      // overflow: five pushes into a four-deep FIFO with no consumer
      for (int i = 1; i <= 5; i++) cycle(1'b1, 1'b0, 12'hFF1, 32'(i), 1'b0);
      cycle(1'b0, 1'b1, 12'hFF2, 32'h0, 1'b0);
      cycle(1'b0, 1'b1, 12'hFF1, 32'h0, 1'b0);
      cycle(1'b1, 1'b0, 12'hFF2, 32'h0, 1'b0);
      cycle(1'b0, 1'b1, 12'hFF2, 32'h0, 1'b0);
      for (int i = 0; i < 8 && fq.size() != 0; i++) idle(1, 1'b1);
      cycle(1'b0, 1'b1, 12'hFF2, 32'h0, 1'b1);

      // full FIFO, push and pop together
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 12'hFF1, 32'h100 + 32'(i), 1'b0);
      cycle(1'b1, 1'b0, 12'hFF1, 32'h0000_0055, 1'b1);
      cycle(1'b0, 1'b1, 12'hFF2, 32'h0, 1'b0);
      for (int i = 0; i < 8 && fq.size() != 0; i++) idle(1, 1'b1);

      // overflow set and STATUS clear in the same cycle: set wins
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 12'hFF1, 32'h200 + 32'(i), 1'b0);
      cycle(1'b1, 1'b0, 12'hFF1, 32'h0000_0077, 1'b0);
      cycle(1'b1, 1'b0, 12'hFF2, 32'h0, 1'b0);
      cycle(1'b0, 1'b1, 12'hFF2, 32'h0, 1'b0);
      for (int i = 0; i < 8 && fq.size() != 0; i++) idle(1, 1'b1);
      cycle(1'b1, 1'b0, 12'hFF2, 32'h0, 1'b0);

      // unmapped load and store
      cycle(1'b0, 1'b1, 12'h800, 32'h0, 1'b0);
      cycle(1'b1, 1'b0, 12'hFFF, 32'h1111_1111, 1'b0);
      idle(1, 1'b0);

      // asynchronous reset during an in-flight load with the FIFO occupied
      cycle(1'b1, 1'b0, 12'hFF1, 32'h0000_0AAA, 1'b0);
      cycle(1'b1, 1'b0, 12'hFF1, 32'h0000_0BBB, 1'b0);
      idle(1, 1'b0);
      @(negedge clock);
      rden = 1'b1; wren = 1'b0; address_dmem = 12'hFF3; dbg_ready = 1'b0;
      @(posedge clock); #1;
      check("pre_rst_q_valid", 32'(q_valid), 32'h1);
      #1 reset = 1'b1;
      #1;
      check("async_rst_q_valid", 32'(q_valid), 32'h0);
      check("async_rst_dbg_valid", 32'(dbg_valid), 32'h0);
      check("async_rst_q_dmem", q_dmem, 32'h0);
      rden = 1'b0;
      @(posedge clock); #2;
      reset = 1'b0;
      model_reset();
      cycle(1'b0, 1'b1, 12'hFF2, 32'h0, 1'b0);
      cycle(1'b0, 1'b1, 12'hFF3, 32'h0, 1'b0);
      cycle(1'b0, 1'b1, 12'hFF0, 32'h0, 1'b0);

      // randomized traffic over all regions
      for (int n = 0; n < 400; n++) begin
         sel = int'($urandom_range(0, 9));
         w   = 1'($urandom_range(0, 1));
         r   = 1'($urandom_range(0, 1));
         rdy = ($urandom_range(0, 2) == 0);
         case (sel)
            0, 1, 2: a = 12'h020 + 12'($urandom_range(0, 7));
            3:       a = ($urandom_range(0, 1) == 0) ? 12'h3FF : 12'h020;
            4: begin
               a = 12'hFF0;
               if ($urandom_range(0, 7) != 0) w = 1'b0;
            end
            5, 6:    a = 12'hFF1;
            7:       a = 12'hFF2;
            8:       a = 12'hFF3;
            default: a = ($urandom_range(0, 1) == 0) ? 12'(32'h400 + $urandom_range(0, 12'hBEF))
                                                     : 12'(32'hFF4 + $urandom_range(0, 11));
         endcase
         cycle(w, r, a, $urandom, rdy);
      end
      idle(2, 1'b1);
      @(posedge clock); #2;
      check("scoreboard_drained", 32'(sb.size()), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
